// File: rtl/eboot_dma.sv
// Boot DMA: programs the ELUKS decryptor over Wishbone, streams decrypted bytes
// into RAM as packed words, and holds the CPU in reset until the copy completes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start, CPU held
// CFG     | writing password, start block and HMAC mode to ELUKS
// STAT_RQ | requesting status (write 1 to +6)
// STAT_RD | reading status word (+6)
// CHECK   | validating eluks error flag and block count
// DATA_RD | reading one plaintext byte from +5
// RAM_WR  | writing one assembled word to RAM
// GAP     | one idle bus cycle between transactions (also before a retry)
// DONE    | boot complete, CPU released, terminal until reset
// ERROR   | boot failed, err_code valid, start restarts from CFG
module eboot_dma #(
    parameter int                 WB_DATA       = 32,
    parameter logic [WB_DATA-1:0] ELUKS_WB_ADDR = WB_DATA'(32'h9200_0000),
    parameter logic [WB_DATA-1:0] RAM_WB_ADDR   = '0,
    parameter int                 BLOCK_BYTES   = 512,
    parameter int                 MAX_BLOCKS    = 2048,
    parameter int                 TIMEOUT       = 1024,
    parameter int                 RETRIES       = 3
) (
    input  logic                   wb_clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [63:0]            psw,
    input  logic [31:0]            start_block,
    input  logic                   hmac_enable,
    output logic [WB_DATA-1:0]     wb_adr_o,
    output logic [WB_DATA-1:0]     wb_dat_o,
    output logic [WB_DATA/8-1:0]   wb_sel_o,
    output logic                   wb_we_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic [2:0]             wb_cti_o,
    output logic [1:0]             wb_bte_o,
    input  logic [WB_DATA-1:0]     wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_rty_i,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [2:0]             err_code,
    output logic [31:0]            words_copied,
    output logic [63:0]            exec_timer
);

    localparam int BPW   = WB_DATA / 8;
    localparam int BC_W  = $clog2(BPW) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int RTY_W = $clog2(RETRIES + 2);

    localparam logic [TMO_W-1:0]   TMO_LOAD = TMO_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0]   RTY_MAX  = RTY_W'(RETRIES);
    localparam logic [BC_W-1:0]    BC_LAST  = BC_W'(BPW - 1);
    localparam logic [WB_DATA-2:0] MAX_B    = (WB_DATA-1)'(MAX_BLOCKS);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CFG     = 4'd1;
    localparam logic [3:0] S_STAT_RQ = 4'd2;
    localparam logic [3:0] S_STAT_RD = 4'd3;
    localparam logic [3:0] S_CHECK   = 4'd4;
    localparam logic [3:0] S_DATA_RD = 4'd5;
    localparam logic [3:0] S_RAM_WR  = 4'd6;
    localparam logic [3:0] S_GAP     = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;
    localparam logic [3:0] S_ERROR   = 4'd9;

    logic [3:0]         r_state;
    logic [3:0]         r_next;
    logic [2:0]         r_cfg_idx;
    logic [BC_W-1:0]    r_byte_cnt;
    logic [RTY_W-1:0]   r_retry;
    logic [TMO_W-1:0]   r_tmo;
    logic [WB_DATA-1:0] r_word;
    logic [WB_DATA-1:0] r_status;
    logic [31:0]        r_words;
    logic [63:0]        r_timer;
    logic [2:0]         r_err_code;
    logic [63:0]        r_psw;
    logic [31:0]        r_start_block;
    logic               r_hmac;

    logic               w_in_txn;
    logic               w_bus_fail;
    logic               w_ack;
    logic               w_fail;
    logic               w_eluks_err;
    logic [WB_DATA-2:0] w_blocks;
    logic [31:0]        w_total_words;

    function automatic logic [WB_DATA-1:0] eluks_adr(input logic [2:0] off);
        return ELUKS_WB_ADDR + WB_DATA'(off) * WB_DATA'(BPW);
    endfunction

    assign w_in_txn = (r_state == S_CFG) || (r_state == S_STAT_RQ) || (r_state == S_STAT_RD) ||
                      (r_state == S_DATA_RD) || (r_state == S_RAM_WR);

    // err/rty override a simultaneous ack; timeout only fires when nothing answered
    assign w_bus_fail = wb_err_i | wb_rty_i;
    assign w_ack      = wb_ack_i & ~w_bus_fail;
    assign w_fail     = w_bus_fail | ((r_tmo == '0) & ~wb_ack_i);

    assign w_eluks_err   = r_status[WB_DATA-1];
    assign w_blocks      = r_status[WB_DATA-2:0];
    assign w_total_words = (32'(w_blocks) * 32'(BLOCK_BYTES)) / 32'(BPW);

    assign wb_cyc_o = w_in_txn;
    assign wb_stb_o = w_in_txn;
    assign wb_sel_o = w_in_txn ? '1 : '0;
    assign wb_cti_o = 3'd0;
    assign wb_bte_o = 2'd0;

    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERROR);
    assign cpu_rst      = (r_state != S_DONE);
    assign err_code     = r_err_code;
    assign words_copied = r_words;
    assign exec_timer   = r_timer;

    always_comb begin
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_we_o  = 1'b0;
        case (r_state)
            S_CFG: begin
                wb_we_o = 1'b1;
                case (r_cfg_idx)
                    3'd0: begin wb_adr_o = eluks_adr(3'd0); wb_dat_o = WB_DATA'(r_psw[63:32]); end
                    3'd1: begin wb_adr_o = eluks_adr(3'd1); wb_dat_o = WB_DATA'(r_psw[31:0]); end
                    3'd2: begin wb_adr_o = eluks_adr(3'd2); wb_dat_o = WB_DATA'(r_start_block); end
                    3'd3: begin wb_adr_o = eluks_adr(3'd4); wb_dat_o = WB_DATA'(r_hmac); end
                    default: begin wb_adr_o = eluks_adr(3'd3); wb_dat_o = WB_DATA'(r_start_block); end
                endcase
            end
            S_STAT_RQ: begin
                wb_we_o  = 1'b1;
                wb_adr_o = eluks_adr(3'd6);
                wb_dat_o = WB_DATA'(1);
            end
            S_STAT_RD: wb_adr_o = eluks_adr(3'd6);
            S_DATA_RD: wb_adr_o = eluks_adr(3'd5);
            S_RAM_WR: begin
                wb_we_o  = 1'b1;
                wb_adr_o = RAM_WB_ADDR + WB_DATA'(r_words) * WB_DATA'(BPW);
                wb_dat_o = r_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_next        <= S_IDLE;
            r_cfg_idx     <= '0;
            r_byte_cnt    <= '0;
            r_retry       <= '0;
            r_tmo         <= '0;
            r_word        <= '0;
            r_status      <= '0;
            r_words       <= '0;
            r_timer       <= '0;
            r_err_code    <= '0;
            r_psw         <= '0;
            r_start_block <= '0;
            r_hmac        <= 1'b0;
        end else begin
            r_tmo <= w_in_txn ? r_tmo - TMO_W'(1) : TMO_LOAD;
            if (busy) r_timer <= r_timer + 64'd1;

            if (w_in_txn && w_fail) begin
                if (r_retry < RTY_MAX) begin
                    r_retry <= r_retry + RTY_W'(1);
                    r_next  <= r_state;
                    r_state <= S_GAP;
                end else begin
                    r_state    <= S_ERROR;
                    r_err_code <= w_bus_fail ? 3'd1 : 3'd2;
                end
            end else begin
                if (w_in_txn && w_ack) r_retry <= '0;
                case (r_state)
                    S_IDLE, S_ERROR: begin
                        if (start) begin
                            r_state       <= S_CFG;
                            r_cfg_idx     <= '0;
                            r_byte_cnt    <= '0;
                            r_retry       <= '0;
                            r_words       <= '0;
                            r_timer       <= '0;
                            r_err_code    <= '0;
                            r_psw         <= psw;
                            r_start_block <= start_block;
                            r_hmac        <= hmac_enable;
                        end
                    end
                    S_CFG: begin
                        if (w_ack) begin
                            r_cfg_idx <= r_cfg_idx + 3'd1;
                            r_next    <= (r_cfg_idx == 3'd4) ? S_STAT_RQ : S_CFG;
                            r_state   <= S_GAP;
                        end
                    end
                    S_STAT_RQ: begin
                        if (w_ack) begin
                            r_next  <= S_STAT_RD;
                            r_state <= S_GAP;
                        end
                    end
                    S_STAT_RD: begin
                        if (w_ack) begin
                            r_status <= wb_dat_i;
                            r_state  <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (w_eluks_err) begin
                            r_err_code <= 3'd4;
                            r_state    <= S_ERROR;
                        end else if (w_blocks > MAX_B) begin
                            r_err_code <= 3'd3;
                            r_state    <= S_ERROR;
                        end else if (w_blocks == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_DATA_RD;
                        end
                    end
                    S_DATA_RD: begin
                        if (w_ack) begin
                            r_word  <= {r_word[WB_DATA-9:0], wb_dat_i[7:0]};
                            r_state <= S_GAP;
                            if (r_byte_cnt == BC_LAST) begin
                                r_byte_cnt <= '0;
                                r_next     <= S_RAM_WR;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + BC_W'(1);
                                r_next     <= S_DATA_RD;
                            end
                        end
                    end
                    S_RAM_WR: begin
                        if (w_ack) begin
                            r_words <= r_words + 32'd1;
                            if (r_words + 32'd1 == w_total_words) begin
                                r_state <= S_DONE;
                            end else begin
                                r_next  <= S_DATA_RD;
                                r_state <= S_GAP;
                            end
                        end
                    end
                    S_GAP:   r_state <= r_next;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eboot_dma.sv
// Directed bench for eboot_dma: a scripted Wishbone slave (status word, byte
// source, RAM, per-address fault injection) plus per-scenario check tasks.
module tb_eboot_dma;

    localparam logic [31:0] EB = 32'h9200_0000;

    logic        wb_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] psw = 64'h1122_3344_5566_7788;
    logic [31:0] start_block = 32'h10;
    logic        hmac_enable = 1'b1;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        cpu_rst, busy, done, error;
    logic [2:0]  err_code;
    logic [31:0] words_copied;
    logic [63:0] exec_timer;

    int checks = 0;
    int errors = 0;

    // slave configuration (written by tests only)
    logic [31:0] status_val = 32'h1;
    logic [31:0] fault_adr [2] = '{32'h0, 32'h0};
    int          fault_left[2] = '{0, 0};
    int          fault_kind[2] = '{0, 0};   // 1 err, 2 rty, 3 ack+err, 4 silent

    // slave state (written by the slave process only)
    logic [31:0] a_adr[$];
    logic [31:0] a_dat[$];
    logic        a_we[$];
    logic [31:0] ram_mem[256];
    int          ram_n, stable_bad, gap_bad, low_run, kind;
    int          fault_used[2];
    logic [7:0]  byte_ctr;
    logic        in_att, prev_cyc, prev_busy, cur_we;
    logic [31:0] cur_adr, cur_dat;

    always #5 wb_clk = ~wb_clk;

    eboot_dma dut (
        .wb_clk(wb_clk), .rst_n(rst_n), .start(start), .psw(psw),
        .start_block(start_block), .hmac_enable(hmac_enable),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .words_copied(words_copied), .exec_timer(exec_timer)
    );

    always @(negedge wb_clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_dat_i = 32'h0;
        if (!rst_n) begin
            in_att = 1'b0; ram_n = 0; byte_ctr = 8'h0; stable_bad = 0; gap_bad = 0;
            low_run = 0; prev_cyc = 1'b0; prev_busy = 1'b0;
            fault_used = '{0, 0};
            a_adr.delete(); a_dat.delete(); a_we.delete();
        end else begin
            // bus must idle exactly one cycle between transactions of a run
            if (wb_cyc_o) begin
                if (!prev_cyc && prev_busy && low_run != 1) gap_bad++;
                low_run = 0;
            end else if (busy) begin
                low_run++;
            end
            prev_cyc  = wb_cyc_o;
            prev_busy = busy;

            if (!(wb_cyc_o && wb_stb_o)) begin
                in_att = 1'b0;
            end else if (in_att) begin
                if (wb_adr_o !== cur_adr || wb_dat_o !== cur_dat || wb_we_o !== cur_we ||
                    wb_sel_o !== 4'hF) stable_bad++;
            end else begin
                in_att = 1'b1;
                cur_adr = wb_adr_o; cur_dat = wb_dat_o; cur_we = wb_we_o;
                a_adr.push_back(wb_adr_o); a_dat.push_back(wb_dat_o); a_we.push_back(wb_we_o);
                if (wb_sel_o !== 4'hF) stable_bad++;
                kind = 0;
                for (int s = 0; s < 2; s++) begin
                    if (kind == 0 && fault_used[s] < fault_left[s] && wb_adr_o == fault_adr[s]) begin
                        kind = fault_kind[s];
                        fault_used[s]++;
                    end
                end
                case (kind)
                    0: begin
                        wb_ack_i = 1'b1;
                        if (!wb_we_o && wb_adr_o == EB + 32'd24) begin
                            wb_dat_i = status_val;
                        end else if (!wb_we_o && wb_adr_o == EB + 32'd20) begin
                            wb_dat_i = {24'hA5C3E7, byte_ctr};
                            byte_ctr++;
                        end else if (wb_we_o && wb_adr_o < EB) begin
                            ram_mem[wb_adr_o[9:2]] = wb_dat_o;
                            ram_n++;
                        end
                    end
                    1: wb_err_i = 1'b1;
                    2: wb_rty_i = 1'b1;
                    3: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        fault_left = '{0, 0};
        status_val = 32'h1;
        repeat (2) @(negedge wb_clk);
        rst_n = 1'b1;
        @(negedge wb_clk);
    endtask

    task automatic pulse_start();
        @(negedge wb_clk);
        start = 1'b1;
        @(negedge wb_clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string nm);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge wb_clk);
            n++;
        end
        checks++;
        if (!(done || error)) begin
            errors++;
            $display("FAIL %s_end: no done/error after %0d cycles", nm, budget);
        end
    endtask

    function automatic int count_adr(input logic [31:0] adr);
        int c = 0;
        foreach (a_adr[i]) if (a_adr[i] == adr) c++;
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge wb_clk);
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== '0) begin
            errors++; $display("FAIL rst_wb: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h want all 0",
                               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o); end
        checks++; if ({busy, done, error, err_code} !== 6'b0) begin
            errors++; $display("FAIL rst_status: busy=%b done=%b error=%b code=%0d want 0", busy, done, error, err_code); end
        checks++; if (words_copied !== 32'd0 || exec_timer !== 64'd0) begin
            errors++; $display("FAIL rst_counters: words=%0d timer=%0d want 0", words_copied, exec_timer); end
        rst_n = 1'b1;
        @(negedge wb_clk);
    endtask

    task automatic test_boot_one_block();
        logic [31:0] ea[7] = '{EB, EB + 32'd4, EB + 32'd8, EB + 32'd16, EB + 32'd12, EB + 32'd24, EB + 32'd24};
        logic [31:0] ed[7] = '{32'h1122_3344, 32'h5566_7788, 32'h10, 32'h1, 32'h10, 32'h1, 32'h0};
        logic        ew[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] w;
        int bad = 0;
        int n0;
        do_reset();
        status_val = 32'h1;
        pulse_start();
        checks++; if (busy !== 1'b1 || cpu_rst !== 1'b1) begin
            errors++; $display("FAIL boot_busy: busy=%b cpu_rst=%b want 1 1", busy, cpu_rst); end
        wait_end(5000, "boot");
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (a_adr[i] !== ea[i] || a_we[i] !== ew[i] || (ew[i] && a_dat[i] !== ed[i])) begin
                errors++; $display("FAIL boot_seq%0d: adr=%h we=%b dat=%h want adr=%h we=%b dat=%h",
                                   i, a_adr[i], a_we[i], a_dat[i], ea[i], ew[i], ed[i]); end
        end
        checks++; if (done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL boot_status: done=%b error=%b cpu_rst=%b busy=%b want 1 0 0 0", done, error, cpu_rst, busy); end
        checks++; if (ram_n !== 128 || words_copied !== 32'd128) begin
            errors++; $display("FAIL boot_count: ram writes=%0d words=%0d want 128", ram_n, words_copied); end
        checks++; if (a_adr.size() !== 647) begin
            errors++; $display("FAIL boot_txns: got %0d transactions want 647", a_adr.size()); end
        checks++; if (ram_mem[0] !== 32'h0001_0203) begin
            errors++; $display("FAIL boot_word0: got %h want 00010203", ram_mem[0]); end
        checks++; if (ram_mem[127] !== 32'hFCFD_FEFF) begin
            errors++; $display("FAIL boot_word127: got %h want fcfdfeff", ram_mem[127]); end
        for (int i = 0; i < 128; i++) begin
            w = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
            if (ram_mem[i] !== w) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL boot_words: %0d wrong words want 0", bad); end
        checks++; if (exec_timer !== 64'd1293) begin
            errors++; $display("FAIL boot_timer: got %0d want 1293", exec_timer); end
        checks++; if (stable_bad !== 0 || gap_bad !== 0) begin
            errors++; $display("FAIL boot_bus: unstable=%0d bad gaps=%0d want 0 0", stable_bad, gap_bad); end
        n0 = a_adr.size();
        pulse_start();
        repeat (5) @(negedge wb_clk);
        checks++; if (done !== 1'b1 || a_adr.size() !== n0 || exec_timer !== 64'd1293) begin
            errors++; $display("FAIL done_terminal: done=%b txns=%0d timer=%0d want 1 %0d 1293", done, a_adr.size(), exec_timer, n0); end
    endtask

    task automatic test_status_errors();
        do_reset();
        status_val = 32'h8000_0001;
        pulse_start();
        wait_end(500, "eluks");
        checks++; if (error !== 1'b1 || err_code !== 3'd4 || cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL eluks_err: error=%b code=%0d cpu_rst=%b busy=%b done=%b want 1 4 1 0 0",
                               error, err_code, cpu_rst, busy, done); end
        checks++; if (ram_n !== 0) begin errors++; $display("FAIL eluks_ram: got %0d writes want 0", ram_n); end
        do_reset();
        status_val = 32'd2049;
        pulse_start();
        wait_end(500, "toobig");
        checks++; if (error !== 1'b1 || err_code !== 3'd3 || ram_n !== 0) begin
            errors++; $display("FAIL too_many_blocks: error=%b code=%0d ram=%0d want 1 3 0", error, err_code, ram_n); end
    endtask

    task automatic test_retry();
        int c10, c20, same;
        do_reset();
        status_val = 32'h1;
        fault_adr  = '{32'h10, 32'h20};
        fault_kind = '{1, 2};
        fault_left = '{2, 3};
        pulse_start();
        wait_end(5000, "retry");
        c10 = count_adr(32'h10);
        c20 = count_adr(32'h20);
        same = 0;
        foreach (a_adr[i]) if (a_adr[i] == 32'h10 && a_we[i] && a_dat[i] == 32'h1011_1213) same++;
        checks++; if (done !== 1'b1 || ram_n !== 128) begin
            errors++; $display("FAIL retry_done: done=%b ram=%0d want 1 128", done, ram_n); end
        checks++; if (c10 !== 3 || same !== 3) begin
            errors++; $display("FAIL retry_err_reissue: tries=%0d identical=%0d want 3 3", c10, same); end
        checks++; if (c20 !== 4 || ram_mem[8] !== 32'h2021_2223) begin
            errors++; $display("FAIL retry_rty_reset: tries=%0d word=%h want 4 20212223", c20, ram_mem[8]); end
        checks++; if (ram_mem[4] !== 32'h1011_1213) begin
            errors++; $display("FAIL retry_word4: got %h want 10111213", ram_mem[4]); end
        do_reset();
        status_val = 32'h1;
        fault_adr  = '{EB + 32'd8, 32'h0};
        fault_kind = '{3, 0};
        fault_left = '{4, 0};
        pulse_start();
        wait_end(500, "errfail");
        checks++; if (error !== 1'b1 || err_code !== 3'd1) begin
            errors++; $display("FAIL err_exhaust: error=%b code=%0d want 1 1", error, err_code); end
        checks++; if (count_adr(EB + 32'd8) !== 4 || ram_n !== 0) begin
            errors++; $display("FAIL err_tries: tries=%0d ram=%0d want 4 0", count_adr(EB + 32'd8), ram_n); end
    endtask

    task automatic test_timeout_restart();
        int base;
        do_reset();
        status_val = 32'h0;
        fault_adr  = '{EB, 32'h0};
        fault_kind = '{4, 0};
        fault_left = '{4, 0};
        pulse_start();
        wait_end(6000, "timeout");
        checks++; if (error !== 1'b1 || err_code !== 3'd2 || a_adr.size() !== 4) begin
            errors++; $display("FAIL timeout_err: error=%b code=%0d tries=%0d want 1 2 4", error, err_code, a_adr.size()); end
        checks++; if (exec_timer !== 64'd4099) begin
            errors++; $display("FAIL timeout_timer: got %0d want 4099", exec_timer); end
        checks++; if (stable_bad !== 0) begin
            errors++; $display("FAIL timeout_stable: %0d changes while waiting want 0", stable_bad); end
        repeat (10) @(negedge wb_clk);
        checks++; if (exec_timer !== 64'd4099) begin
            errors++; $display("FAIL timer_frozen: got %0d want 4099", exec_timer); end
        base = a_adr.size();
        pulse_start();
        checks++; if (error !== 1'b0 || err_code !== 3'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL restart_clear: error=%b code=%0d busy=%b want 0 0 1", error, err_code, busy); end
        wait_end(500, "restart");
        checks++; if (a_adr[base] !== EB || a_dat[base] !== 32'h1122_3344) begin
            errors++; $display("FAIL restart_first: adr=%h dat=%h want %h 11223344", a_adr[base], a_dat[base], EB); end
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0 || a_adr.size() - base !== 7 || ram_n !== 0) begin
            errors++; $display("FAIL zero_blocks: done=%b cpu_rst=%b txns=%0d ram=%0d want 1 0 7 0",
                               done, cpu_rst, a_adr.size() - base, ram_n); end
        checks++; if (exec_timer !== 64'd14) begin
            errors++; $display("FAIL zero_timer: got %0d want 14", exec_timer); end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        do_reset();
        status_val = 32'h1;
        fault_adr  = '{32'h8, 32'h0};
        fault_kind = '{4, 0};
        fault_left = '{1, 0};
        pulse_start();
        while (!(wb_cyc_o && wb_we_o && wb_adr_o == 32'h8) && n < 500) begin
            @(negedge wb_clk);
            n++;
        end
        checks++; if (!(wb_cyc_o && wb_we_o && wb_adr_o == 32'h8) || words_copied !== 32'd2) begin
            errors++; $display("FAIL midrst_reach: cyc=%b adr=%h words=%0d want 1 00000008 2", wb_cyc_o, wb_adr_o, words_copied); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            errors++; $display("FAIL midrst_drop: cyc=%b stb=%b want 0 0", wb_cyc_o, wb_stb_o); end
        checks++; if (busy !== 1'b0 || cpu_rst !== 1'b1 || words_copied !== 32'd0 || exec_timer !== 64'd0) begin
            errors++; $display("FAIL midrst_idle: busy=%b cpu_rst=%b words=%0d timer=%0d want 0 1 0 0",
                               busy, cpu_rst, words_copied, exec_timer); end
        @(negedge wb_clk);
        rst_n = 1'b1;
        repeat (5) @(negedge wb_clk);
        checks++; if (wb_cyc_o !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_no_resume: cyc=%b busy=%b want 0 0", wb_cyc_o, busy); end
    endtask

    initial begin
        test_reset();
        test_boot_one_block();
        test_status_errors();
        test_retry();
        test_timeout_restart();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
